// File: rtl/lr35902_tim_multi.sv
// Multi-channel LR35902-style timer: one free-running divider drives NCH prescaled
// counters with reload, one-shot mode and per-channel interrupt flags.
module lr35902_tim_multi #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned ADR_W = 4,
    parameter int unsigned QUIRK = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [DIV_W-1:0] o_div,
    output logic [7:0]       o_dout,
    input  logic [7:0]       i_din,
    input  logic [ADR_W-1:0] i_adr,
    input  logic             i_read,
    input  logic             i_write,
    output logic             o_irq
);

    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_dout;
    logic             r_irq;
    logic             r_read_q;
    logic             r_write_q;
    logic             r_pend_vld;
    logic [ADR_W-1:0] r_pend_adr;
    logic [7:0]       r_pend_din;

    logic [DIV_W-1:0] w_div_inc;
    logic [DIV_W-1:0] w_div_post;
    logic             w_tick;
    logic             w_apply;
    logic             w_wr_div;
    logic             w_rd_rise;
    logic             w_wr_fall;
    logic [7:0]       w_rd_data;

    logic [NCH-1:0][7:0] w_cnt_rd;
    logic [NCH-1:0][7:0] w_rld_rd;
    logic [NCH-1:0][7:0] w_ctl_rd;
    logic [NCH-1:0]      w_irq_ch;

    assign w_div_inc = r_div + DIV_W'(1);
    assign w_tick    = &w_div_inc[1:0];
    assign w_apply   = w_tick & r_pend_vld;
    assign w_wr_div  = w_apply && (r_pend_adr == '0);
    // A DIV write keeps the two prescale bits so the tick cadence is undisturbed.
    assign w_div_post = w_wr_div ? {{(DIV_W-2){1'b0}}, w_div_inc[1:0]} : w_div_inc;
    assign w_rd_rise  = i_read & ~r_read_q;
    assign w_wr_fall  = ~i_write & r_write_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [ADR_W-1:0] AdrCnt = ADR_W'(1 + 3 * c);
        localparam logic [ADR_W-1:0] AdrRld = ADR_W'(2 + 3 * c);
        localparam logic [ADR_W-1:0] AdrCtl = ADR_W'(3 + 3 * c);

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_rld;
        logic [1:0]       r_tap;
        logic             r_en;
        logic             r_os;
        logic             r_ie;
        logic             r_if;
        logic             r_tbit;

        logic [CNT_W-1:0] w_cnt_d;
        logic [CNT_W-1:0] w_rld_d;
        logic [CNT_W-1:0] w_cnt_base;
        logic [1:0]       w_tap_d;
        logic             w_en_d;
        logic             w_os_d;
        logic             w_ie_d;
        logic             w_if_d;
        logic             w_tbit_d;
        logic             w_tap_bit;
        logic             w_edge;
        logic             w_wr_cnt;
        logic             w_wr_rld;
        logic             w_wr_ctl;

        assign w_wr_cnt = w_apply && (r_pend_adr == AdrCnt);
        assign w_wr_rld = w_apply && (r_pend_adr == AdrRld);
        assign w_wr_ctl = w_apply && (r_pend_adr == AdrCtl);

        always_comb begin
            w_tap_d    = r_tap;
            w_en_d     = r_en;
            w_os_d     = r_os;
            w_ie_d     = r_ie;
            w_if_d     = r_if;
            w_rld_d    = r_rld;
            w_cnt_base = r_cnt;
            w_tbit_d   = r_tbit;
            w_tap_bit  = 1'b0;
            w_edge     = 1'b0;
            if (w_wr_ctl) begin
                w_tap_d = r_pend_din[1:0];
                w_en_d  = r_pend_din[2];
                w_os_d  = r_pend_din[3];
                w_ie_d  = r_pend_din[4];
                if (r_pend_din[5]) begin
                    w_if_d = 1'b0;
                end
            end
            if (w_wr_rld) begin
                w_rld_d = r_pend_din[CNT_W-1:0];
            end
            if (w_wr_cnt) begin
                w_cnt_base = r_pend_din[CNT_W-1:0];
            end
            w_cnt_d = w_cnt_base;
            case (w_tap_d)
                2'd0: w_tap_bit = w_div_post[9];
                2'd1: w_tap_bit = w_div_post[3];
                2'd2: w_tap_bit = w_div_post[5];
                2'd3: w_tap_bit = w_div_post[7];
                default: w_tap_bit = 1'b0;
            endcase
            if (w_tick) begin
                w_tbit_d = w_en_d & w_tap_bit;
                w_edge   = r_tbit & ~w_tbit_d;
                if (QUIRK == 0 && (w_en_d != r_en || w_tap_d != r_tap)) begin
                    w_edge = 1'b0;
                end
                // Overflow reload and IF set take priority over any same-tick write.
                if (w_edge) begin
                    if (&w_cnt_base) begin
                        w_cnt_d = w_rld_d;
                        w_if_d  = 1'b1;
                        if (w_os_d) begin
                            w_en_d = 1'b0;
                        end
                    end else begin
                        w_cnt_d = w_cnt_base + CNT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_cnt  <= '0;
                r_rld  <= '0;
                r_tap  <= 2'd0;
                r_en   <= 1'b0;
                r_os   <= 1'b0;
                r_ie   <= 1'b0;
                r_if   <= 1'b0;
                r_tbit <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_d;
                r_rld  <= w_rld_d;
                r_tap  <= w_tap_d;
                r_en   <= w_en_d;
                r_os   <= w_os_d;
                r_ie   <= w_ie_d;
                r_if   <= w_if_d;
                r_tbit <= w_tbit_d;
            end
        end

        assign w_cnt_rd[c] = 8'(r_cnt);
        assign w_rld_rd[c] = 8'(r_rld);
        assign w_ctl_rd[c] = {2'b11, r_if, r_ie, r_os, r_en, r_tap};
        assign w_irq_ch[c] = r_if & r_ie;
    end

    always_comb begin
        w_rd_data = 8'hFF;
        if (i_adr == '0) begin
            w_rd_data = r_div[DIV_W-1 -: 8];
        end
        for (int c = 0; c < NCH; c++) begin
            if (i_adr == ADR_W'(1 + 3 * c)) w_rd_data = w_cnt_rd[c];
            if (i_adr == ADR_W'(2 + 3 * c)) w_rd_data = w_rld_rd[c];
            if (i_adr == ADR_W'(3 + 3 * c)) w_rd_data = w_ctl_rd[c];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div      <= '0;
            r_dout     <= 8'h00;
            r_irq      <= 1'b0;
            r_read_q   <= 1'b0;
            r_write_q  <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_adr <= '0;
            r_pend_din <= 8'h00;
        end else begin
            r_div     <= w_div_post;
            r_read_q  <= i_read;
            r_write_q <= i_write;
            r_irq     <= |w_irq_ch;
            if (w_rd_rise) begin
                r_dout <= w_rd_data;
            end
            // An edge on a tick clk is held for the following tick.
            if (w_wr_fall) begin
                r_pend_vld <= 1'b1;
                r_pend_adr <= i_adr;
                r_pend_din <= i_din;
            end else if (w_tick) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign o_div  = r_div;
    assign o_dout = r_dout;
    assign o_irq  = r_irq;

endmodule

// File: tb/tb_lr35902_tim_multi.sv
// Directed bench for lr35902_tim_multi; a second instance with QUIRK=0 shares the bus
// so disable-edge behaviour can be compared side by side.
module tb_lr35902_tim_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [3:0]  adr = 4'h0;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic [7:0]  dout_a;
    logic [7:0]  dout_b;
    logic        irq_a;
    logic        irq_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    lr35902_tim_multi u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .o_div   (div_a),
        .o_dout  (dout_a),
        .i_din   (din),
        .i_adr   (adr),
        .i_read  (rd),
        .i_write (wr),
        .o_irq   (irq_a)
    );

    lr35902_tim_multi #(.QUIRK(0)) u_dut_q0 (
        .i_clk   (clk),
        .i_reset (rst),
        .o_div   (div_b),
        .o_dout  (dout_b),
        .i_din   (din),
        .i_adr   (adr),
        .i_read  (rd),
        .i_write (wr),
        .o_irq   (irq_b)
    );

    always #5 clk = ~clk;

    // Bench-side divider model: clocks since reset release.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        rd  = 1'b0;
        wr  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] v);
        adr = a;
        din = v;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write_apply(input logic [3:0] a, input logic [7:0] v);
        bus_write(a, v);
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic [7:0] dq);
        adr = a;
        rd  = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d  = dout_a;
        dq = dout_b;
        @(negedge clk);
    endtask

    task automatic wait_phase(input int m, input int v);
        int n = 0;
        @(negedge clk);
        while ((cyc % m) != v && n < 64) begin
            @(negedge clk);
            n++;
        end
        if ((cyc % m) != v) begin
            total++; bad++;
            $display("FAIL wait_phase timeout cyc=%0d want phase %0d mod %0d", cyc, v, m);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) begin
            total++; bad++;
            $display("FAIL wait_cyc timeout cyc=%0d want %0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d, dq;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (div_a !== 16'h0 || dout_a !== 8'h00 || irq_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs got div=%h dout=%h irq=%b want 0/0/0", div_a, dout_a, irq_a);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (div_a !== 16'd10) begin
            bad++; $display("FAIL div_count got=%0d want=10", div_a);
        end
        bus_read(4'd3, d, dq);
        total++;
        if (d !== 8'hC0) begin
            bad++; $display("FAIL reset_ctl0 got=%h want=c0", d);
        end
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL reset_cnt0 got=%h want=00", d);
        end
    endtask

    task automatic test_count();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd2, 8'hF0);
        bus_write_apply(4'd3, 8'h05);
        wait_phase(16, 4);
        bus_write(4'd1, 8'hFE);
        wait_phase(16, 8);
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'hFE) begin
            bad++; $display("FAIL cnt_loaded got=%h want=fe", d);
        end
        wait_phase(16, 4);
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'hFF) begin
            bad++; $display("FAIL cnt_inc got=%h want=ff", d);
        end
        wait_phase(16, 4);
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'hF0) begin
            bad++; $display("FAIL cnt_reload got=%h want=f0", d);
        end
        bus_read(4'd3, d, dq);
        total++;
        if (d !== 8'hE5) begin
            bad++; $display("FAIL ctl_if_set got=%h want=e5", d);
        end
    endtask

    task automatic test_irq();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd2, 8'hF0);
        bus_write_apply(4'd3, 8'h15);
        wait_phase(16, 4);
        bus_write(4'd1, 8'hFF);
        wait_phase(16, 3);
        total++;
        if (irq_a !== 1'b0) begin
            bad++; $display("FAIL irq_early got=%b want=0", irq_a);
        end
        @(negedge clk);
        total++;
        if (irq_a !== 1'b1) begin
            bad++; $display("FAIL irq_rise got=%b want=1", irq_a);
        end
        bus_read(4'd3, d, dq);
        total++;
        if (d !== 8'hF5) begin
            bad++; $display("FAIL irq_ctl0 got=%h want=f5", d);
        end
        bus_read(4'd6, d, dq);
        total++;
        if (d !== 8'hC0) begin
            bad++; $display("FAIL ch1_ctl_untouched got=%h want=c0", d);
        end
        bus_read(4'd4, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL ch1_cnt_untouched got=%h want=00", d);
        end
        bus_write(4'd3, 8'h35);
        repeat (6) @(negedge clk);
        total++;
        if (irq_a !== 1'b0) begin
            bad++; $display("FAIL irq_clear got=%b want=0", irq_a);
        end
        bus_read(4'd3, d, dq);
        total++;
        if (d !== 8'hD5) begin
            bad++; $display("FAIL if_cleared got=%h want=d5", d);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd5, 8'h40);
        bus_write_apply(4'd6, 8'h0D);
        wait_phase(16, 4);
        bus_write(4'd4, 8'hFF);
        wait_phase(16, 5);
        bus_read(4'd6, d, dq);
        total++;
        if (d !== 8'hE9) begin
            bad++; $display("FAIL oneshot_ctl got=%h want=e9", d);
        end
        bus_read(4'd4, d, dq);
        total++;
        if (d !== 8'h40) begin
            bad++; $display("FAIL oneshot_reload got=%h want=40", d);
        end
        repeat (2048) @(negedge clk);
        bus_read(4'd4, d, dq);
        total++;
        if (d !== 8'h40) begin
            bad++; $display("FAIL oneshot_frozen got=%h want=40", d);
        end
        total++;
        if (irq_a !== 1'b0) begin
            bad++; $display("FAIL oneshot_no_irq got=%b want=0", irq_a);
        end
    endtask

    task automatic test_quirk();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd3, 8'h05);
        wait_phase(16, 4);
        bus_write(4'd1, 8'h10);
        wait_phase(16, 12);
        bus_write(4'd3, 8'h00);
        repeat (4) @(negedge clk);
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'h11) begin
            bad++; $display("FAIL quirk1_inc got=%h want=11", d);
        end
        total++;
        if (dq !== 8'h10) begin
            bad++; $display("FAIL quirk0_noinc got=%h want=10", dq);
        end
        repeat (40) @(negedge clk);
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'h11) begin
            bad++; $display("FAIL quirk1_hold got=%h want=11", d);
        end
    endtask

    task automatic test_div_write();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd3, 8'h04);
        bus_write_apply(4'd1, 8'h20);
        wait_cyc(590);
        bus_read(4'd0, d, dq);
        total++;
        if (d !== 8'h02) begin
            bad++; $display("FAIL div_read got=%h want=02", d);
        end
        wait_cyc(600);
        bus_write(4'd0, 8'hAB);
        @(negedge clk);
        total++;
        if (div_a !== 16'd3) begin
            bad++; $display("FAIL div_zeroed got=%0d want=3", div_a);
        end
        bus_read(4'd0, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL div_read_zero got=%h want=00", d);
        end
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'h21 || dq !== 8'h21) begin
            bad++; $display("FAIL div_write_edge got=%h/%h want=21/21", d, dq);
        end
        bus_write_apply(4'd7, 8'h99);
        bus_read(4'd7, d, dq);
        total++;
        if (d !== 8'hFF) begin
            bad++; $display("FAIL unused_adr7 got=%h want=ff", d);
        end
        bus_read(4'd15, d, dq);
        total++;
        if (d !== 8'hFF) begin
            bad++; $display("FAIL unused_adr15 got=%h want=ff", d);
        end
        bus_read(4'd4, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL unused_write_leak got=%h want=00", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, dq;
        do_reset();
        wait_phase(4, 2);
        bus_write(4'd2, 8'h11);
        bus_write(4'd5, 8'h22);
        repeat (6) @(negedge clk);
        bus_read(4'd2, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL b2b_overwritten got=%h want=00", d);
        end
        bus_read(4'd5, d, dq);
        total++;
        if (d !== 8'h22) begin
            bad++; $display("FAIL b2b_last got=%h want=22", d);
        end
    endtask

    task automatic test_reset_pending();
        logic [7:0] d, dq;
        do_reset();
        bus_write_apply(4'd2, 8'h33);
        bus_write_apply(4'd3, 8'h15);
        wait_phase(16, 4);
        bus_write(4'd1, 8'hFF);
        wait_phase(16, 6);
        total++;
        if (irq_a !== 1'b1) begin
            bad++; $display("FAIL rp_irq_pre got=%b want=1", irq_a);
        end
        bus_read(4'd2, d, dq);
        total++;
        if (d !== 8'h33) begin
            bad++; $display("FAIL rp_rld_pre got=%h want=33", d);
        end
        wait_phase(4, 0);
        bus_write(4'd2, 8'h55);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (irq_a !== 1'b0 || div_a !== 16'h0 || dout_a !== 8'h00) begin
            bad++;
            $display("FAIL rp_outs got irq=%b div=%h dout=%h want 0/0/0", irq_a, div_a, dout_a);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        bus_read(4'd2, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL rp_write_dropped got=%h want=00", d);
        end
        bus_read(4'd1, d, dq);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL rp_cnt got=%h want=00", d);
        end
        bus_read(4'd3, d, dq);
        total++;
        if (d !== 8'hC0 || irq_a !== 1'b0) begin
            bad++; $display("FAIL rp_ctl_irq got=%h/%b want=c0/0", d, irq_a);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_irq();
        test_oneshot();
        test_quirk();
        test_div_write();
        test_back_to_back();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
